// File: rtl/arb_2_to_1_sel.sv
// Two-requester round-robin arbiter with transaction locking, steering a 2:1 mux; grant/sel registered, 1-cycle req->gnt latency.
// No data backpressure: a waiting requester simply holds req until granted; fairness timeout bounds the wait when MAX_HOLD != 0.
module arb_2_to_1_sel #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic last0,
    input  logic last1,
    output logic gnt0,
    output logic gnt1,
    output logic sel,
    output logic busy,
    output logic timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ptr;
    logic             w_ptr_nxt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_nxt;
    logic             r_gnt0, r_gnt1, r_sel, r_busy, r_timeout;
    logic             w_gnt0_nxt, w_gnt1_nxt, w_sel_nxt, w_busy_nxt, w_timeout_nxt;

    logic w_owned;
    logic w_own_req, w_own_last, w_oth_req;
    logic w_release, w_force;

    assign w_owned    = (r_state == OWN0) || (r_state == OWN1);
    assign w_own_req  = (r_state == OWN1) ? req1  : req0;
    assign w_own_last = (r_state == OWN1) ? last1 : last0;
    assign w_oth_req  = (r_state == OWN1) ? req0  : req1;
    assign w_release  = w_owned && ((w_own_last && w_own_req) || !w_own_req);
    // Release wins over the fairness timeout when both land on the same edge.
    assign w_force    = w_owned && (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST)
                        && w_oth_req && !w_release;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= 1'b0;
            r_hold_cnt <= '0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_sel      <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_gnt0     <= w_gnt0_nxt;
            r_gnt1     <= w_gnt1_nxt;
            r_sel      <= w_sel_nxt;
            r_busy     <= w_busy_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (req0 && !req1)      w_state_nxt = OWN0;
                else if (!req0 && req1) w_state_nxt = OWN1;
                else if (req0 && req1)  w_state_nxt = r_ptr ? OWN1 : OWN0;
            end
            OWN0: begin
                if (w_release || w_force) begin
                    w_ptr_nxt   = 1'b1;
                    w_state_nxt = req1 ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (w_release || w_force) begin
                    w_ptr_nxt   = 1'b0;
                    w_state_nxt = req0 ? OWN0 : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic: decoded from the next state so every output is a flop
    always_comb begin
        w_gnt0_nxt    = (w_state_nxt == OWN0);
        w_gnt1_nxt    = (w_state_nxt == OWN1);
        w_busy_nxt    = w_gnt0_nxt || w_gnt1_nxt;
        w_timeout_nxt = w_force;
        w_sel_nxt     = r_sel;
        if (w_gnt0_nxt)      w_sel_nxt = 1'b0;
        else if (w_gnt1_nxt) w_sel_nxt = 1'b1;

        w_hold_nxt = r_hold_cnt;
        if (w_busy_nxt && (w_state_nxt != r_state))
            w_hold_nxt = '0;
        else if (w_owned && (r_hold_cnt != CNT_MAX))
            w_hold_nxt = r_hold_cnt + 1'b1;
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign sel     = r_sel;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_arb_2_to_1_sel.sv
// Directed bench for arb_2_to_1_sel; outputs are compared as {gnt0,gnt1,sel,busy,timeout}.
module tb_arb_2_to_1_sel;

    logic clk = 1'b0;
    logic rst, req0, req1, last0, last1;
    logic gnt0, gnt1, sel, busy, timeout;

    int n_chk  = 0;
    int n_fail = 0;

    arb_2_to_1_sel #(.MAX_HOLD(16), .CNT_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .last0   (last0),
        .last1   (last1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] act, input logic [4:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {g0,g1,sel,busy,to}=%b expected %b", tag, act, exp);
        end
    endtask

    function automatic logic [4:0] obs();
        return {gnt0, gnt1, sel, busy, timeout};
    endfunction

    initial begin
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; last0 = 1'b0; last1 = 1'b0;
        #2;

        // Reset held two edges with both requesting
        step();
        step();
        chk("reset", obs(), 5'b00000);

        // Tie after reset goes to requester 0
        rst = 1'b0;
        step();
        chk("first_grant", obs(), 5'b10010);

        // Alternation: last on every 3rd granted cycle, back-to-back handoff
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("alt_%0d", k), obs(), (((k / 3) % 2) == 1) ? 5'b01110 : 5'b10010);
            last0 = ((k % 3) == 2);
            last1 = ((k % 3) == 2);
            step();
        end
        chk("alt_wrap", obs(), 5'b10010);

        // Both drop: abort to IDLE, sel holds 0
        last0 = 1'b0; last1 = 1'b0; req0 = 1'b0; req1 = 1'b0;
        step();
        chk("alt_idle", obs(), 5'b00000);

        // Single requester 1: four grant cycles then IDLE with sel held at 1
        req1 = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("single_%0d", k), obs(), 5'b01110);
            last1 = (k == 3);
            step();
        end
        req1 = 1'b0; last1 = 1'b0;
        chk("single_idle", obs(), 5'b00100);
        step();
        chk("single_idle_hold", obs(), 5'b00100);

        // Timeout: requester 0 holds without last while 1 waits
        req0 = 1'b1; req1 = 1'b1;
        step();
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("hold0_%0d", k), obs(), 5'b10010);
            step();
        end
        chk("timeout_pulse", obs(), 5'b01111);
        step();
        chk("timeout_one_cycle", obs(), 5'b01110);

        // Requester 1 aborts: requester 0 takes over next edge
        req1 = 1'b0;
        step();
        chk("abort1_handoff", obs(), 5'b10010);

        // No waiter: requester 0 keeps the path well past MAX_HOLD
        for (int k = 0; k < 40; k++) step();
        chk("no_waiter_hold", obs(), 5'b10010);
        step();
        chk("no_waiter_hold2", obs(), 5'b10010);

        // Collision: last0 on the would-be timeout cycle -> plain handoff
        req0 = 1'b0;
        step();
        chk("collide_idle", obs(), 5'b00000);
        req0 = 1'b1;
        step();
        req1 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("collide_hold_%0d", k), obs(), 5'b10010);
            last0 = (k == 15);
            step();
        end
        last0 = 1'b0;
        chk("collide_no_timeout", obs(), 5'b01110);

        // Requester 1 aborts, then requester 0 aborts with 1 pending
        step();
        req1 = 1'b0;
        step();
        chk("abort1_to_0", obs(), 5'b10010);
        step();
        req0 = 1'b0; req1 = 1'b1;
        step();
        chk("abort0_to_1", obs(), 5'b01110);

        // Reset mid-grant, then tie must go to requester 0 with a single beat
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        step();
        chk("reset_mid_grant", obs(), 5'b00000);
        rst = 1'b0;
        step();
        chk("post_reset_tie", obs(), 5'b10010);
        last0 = 1'b1;
        step();
        last0 = 1'b0;
        chk("single_beat_handoff", obs(), 5'b01110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
